// File: rtl/slowfil_outfifo.sv
// Output stage for the slow FIR filter: convergent rounding, saturation to OW bits,
// and a first-word-fall-through FIFO on a valid/ready stream with sticky error flags.
//
// Stream handshake: o_valid means o_data holds the FIFO head; a word is consumed on
// every rising edge where o_valid && i_ready. i_ready while o_valid is low has no effect.
module slowfil_outfifo #(
   parameter int IW     = 31,
   parameter int SHIFT  = 8,
   parameter int OW     = 16,
   parameter int LGFIFO = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ce,
   input  logic [IW-1:0]        i_result,
   input  logic                 i_clear,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [OW-1:0]        o_data,
   output logic [LGFIFO:0]      o_fill,
   output logic                 o_sat,
   output logic                 o_dropped
);

   localparam int TW    = IW - SHIFT;
   localparam int RW    = TW + 1;
   localparam int DEPTH = 1 << LGFIFO;

   localparam logic signed [RW-1:0] MAX_V  = RW'((64'sd1 <<< (OW-1)) - 64'sd1);
   localparam logic signed [RW-1:0] MIN_V  = RW'(-(64'sd1 <<< (OW-1)));
   localparam logic [OW-1:0]        SAT_HI = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0]        SAT_LO = {1'b1, {(OW-1){1'b0}}};

   logic signed [RW-1:0] rnd_w;

   // One guard bit above the truncated value keeps the round-up increment from wrapping.
   generate
      if (SHIFT == 0) begin : g_pass
         assign rnd_w = {i_result[IW-1], i_result};
      end else begin : g_round
         localparam logic [SHIFT-1:0] HALF = SHIFT'(1 << (SHIFT-1));
         logic [TW-1:0]    trunc;
         logic [SHIFT-1:0] frac;
         logic             up;
         assign trunc = i_result[IW-1:SHIFT];
         assign frac  = i_result[SHIFT-1:0];
         assign up    = (frac > HALF) || ((frac == HALF) && trunc[0]);
         assign rnd_w = {trunc[TW-1], trunc} + RW'(up);
      end
   endgenerate

   logic                 s1_valid_q, s1_valid_d;
   logic signed [RW-1:0] s1_data_q, s1_data_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [OW-1:0]        s2_data_q, s2_data_d;
   logic [LGFIFO:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                 sat_q, sat_d, drop_q, drop_d;
   logic [OW-1:0]        mem_q [DEPTH];

   logic clamp_hi, clamp_lo, full, empty, rd_en, wr_en;

   always_comb begin
      s1_valid_d = i_ce;
      s1_data_d  = s1_data_q;
      if (i_ce) s1_data_d = rnd_w;

      clamp_hi   = (s1_data_q > MAX_V);
      clamp_lo   = (s1_data_q < MIN_V);
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_data_q[OW-1:0];
      if (clamp_hi)      s2_data_d = SAT_HI;
      else if (clamp_lo) s2_data_d = SAT_LO;

      // Pointers carry one extra wrap bit so full and empty are distinguishable.
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[LGFIFO] != rd_ptr_q[LGFIFO]) &&
              (wr_ptr_q[LGFIFO-1:0] == rd_ptr_q[LGFIFO-1:0]);
      rd_en = !empty && i_ready;
      wr_en = s2_valid_q && (!full || rd_en);

      wr_ptr_d = wr_ptr_q + {{LGFIFO{1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{LGFIFO{1'b0}}, rd_en};

      // A set event on the same edge as i_clear wins.
      sat_d = i_clear ? 1'b0 : sat_q;
      if (s1_valid_q && (clamp_hi || clamp_lo)) sat_d = 1'b1;
      drop_d = i_clear ? 1'b0 : drop_q;
      if (s2_valid_q && full && !rd_en) drop_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sat_q      <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sat_q      <= sat_d;
         drop_q     <= drop_d;
      end
      s1_data_q <= s1_data_d;
      s2_data_q <= s2_data_d;
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_ptr_q[LGFIFO-1:0]] <= s2_data_q;
   end

   assign o_valid   = !empty;
   assign o_data    = mem_q[rd_ptr_q[LGFIFO-1:0]];
   assign o_fill    = wr_ptr_q - rd_ptr_q;
   assign o_sat     = sat_q;
   assign o_dropped = drop_q;

endmodule

// File: tb/tb_slowfil_outfifo.sv
// Directed bench for slowfil_outfifo with a 4-deep FIFO: rounding, saturation,
// latency/throughput, overflow, full read/write, sticky flags and mid-stream reset.
module tb_slowfil_outfifo;
   localparam int IW = 31;
   localparam int OW = 16;
   localparam int LG = 2;

   logic              clk = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_ce = 1'b0;
   logic [IW-1:0]     i_result = '0;
   logic              i_clear = 1'b0;
   logic              i_ready = 1'b0;
   logic              o_valid;
   logic [OW-1:0]     o_data;
   logic [LG:0]       o_fill;
   logic              o_sat;
   logic              o_dropped;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   slowfil_outfifo #(.IW(IW), .SHIFT(8), .OW(OW), .LGFIFO(LG)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_result(i_result),
      .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_fill(o_fill), .o_sat(o_sat), .o_dropped(o_dropped)
   );

   // Advance one cycle; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
      checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", o_fill); end
      checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b expected 0", o_sat); end
      checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL rst_dropped: got %b expected 0", o_dropped); end
   endtask

   task automatic test_rounding();
      logic signed [IW-1:0] vals [5];
      logic signed [OW-1:0] exp_v [5];
      vals  = '{31'sd384, 31'sd640, 31'sd641, -31'sd384, -31'sd640};
      exp_v = '{16'sd2, 16'sd2, 16'sd3, -16'sd2, -16'sd2};
      i_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         i_ce = (c < 5);
         if (c < 5) i_result = vals[c];
         if (c >= 3 && c < 8) begin
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid c=%0d: got %b expected 1", c, o_valid); end
            checks++; if (o_data !== exp_v[c-3]) begin errors++; $display("FAIL rnd_data c=%0d: got %0d expected %0d", c, $signed(o_data), exp_v[c-3]); end
         end
         step();
      end
      i_ce = 1'b0;
      checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rnd_sat: got %b expected 0", o_sat); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %b expected 0", o_valid); end
   endtask

   task automatic test_saturation();
      i_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         i_ce = (c < 2);
         i_result = (c == 0) ? 31'h3FFF_FF80 : 31'h4000_0000;
         if (c == 2) begin
            checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b expected 1", o_sat); end
         end
         if (c == 3) begin
            checks++; if (o_data !== 16'h7FFF || o_valid !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d/%b expected 32767/1", $signed(o_data), o_valid); end
         end
         if (c == 4) begin
            checks++; if (o_data !== 16'h8000 || o_valid !== 1'b1) begin errors++; $display("FAIL sat_neg: got %0d/%b expected -32768/1", $signed(o_data), o_valid); end
         end
         step();
      end
      i_ce = 1'b0;
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", o_sat); end
      // Clamp on the same edge as i_clear: flag must stay set.
      i_ce = 1'b1;
      i_result = 31'h3FFF_FF80;
      step();
      i_ce = 1'b0;
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b expected 1", o_sat); end
      step();
      checks++; if (o_data !== 16'h7FFF || o_valid !== 1'b1) begin errors++; $display("FAIL sat_set_wins_data: got %0d/%b expected 32767/1", $signed(o_data), o_valid); end
      step();
   endtask

   task automatic test_back_to_back();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      i_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         i_ce = (c < 8);
         i_result = IW'((c + 1) * 256);
         if (c < 3 || c > 10) begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d: got %b expected 0", c, o_valid); end
         end else begin
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d: got %b expected 1", c, o_valid); end
            checks++; if (o_data !== 16'(c - 2)) begin errors++; $display("FAIL b2b_data c=%0d: got %0d expected %0d", c, o_data, c - 2); end
         end
         checks++; if (o_fill > 3'd1) begin errors++; $display("FAIL b2b_fill c=%0d: got %0d expected <=1", c, o_fill); end
         step();
      end
      i_ce = 1'b0;
   endtask

   task automatic test_overflow();
      i_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         i_ce = (c < 6);
         i_result = IW'((c + 1) * 256);
         step();
      end
      i_ce = 1'b0;
      checks++; if (o_fill !== 3'd4) begin errors++; $display("FAIL ovf_fill: got %0d expected 4", o_fill); end
      checks++; if (o_dropped !== 1'b1) begin errors++; $display("FAIL ovf_dropped: got %b expected 1", o_dropped); end
      i_ready = 1'b1;
      for (int d = 0; d < 5; d++) begin
         if (d < 4) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(d + 1)) begin errors++; $display("FAIL ovf_data d=%0d: got %0d/%b expected %0d/1", d, o_data, o_valid, d + 1); end
         end else begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", o_valid); end
         end
         step();
      end
   endtask

   task automatic test_full_rw();
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL frw_clear: got %b expected 0", o_dropped); end
      i_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         i_ce = (c < 4);
         i_result = IW'((c + 1) * 256);
         step();
      end
      // Start the next burst two cycles early so its first write meets the first read.
      for (int c = 0; c < 16; c++) begin
         i_ce = (c < 8);
         i_result = IW'((c + 5) * 256);
         i_ready = (c >= 2);
         if (c <= 10) begin
            checks++; if (o_fill !== 3'd4) begin errors++; $display("FAIL frw_fill c=%0d: got %0d expected 4", c, o_fill); end
         end
         if (c >= 2 && c <= 13) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(c - 1)) begin errors++; $display("FAIL frw_data c=%0d: got %0d/%b expected %0d/1", c, o_data, o_valid, c - 1); end
         end
         if (c == 14) begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL frw_empty: got %b expected 0", o_valid); end
         end
         step();
      end
      i_ce = 1'b0;
      checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL frw_dropped: got %b expected 0", o_dropped); end
   endtask

   task automatic test_reset_midstream();
      i_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         i_ce = (c < 3);
         i_result = (c == 2) ? 31'h3FFF_FF80 : IW'((c + 1) * 256);
         step();
      end
      checks++; if (o_fill !== 3'd3 || o_sat !== 1'b1) begin errors++; $display("FAIL mrst_pre: got fill %0d sat %b expected 3/1", o_fill, o_sat); end
      i_ce = 1'b1;
      i_result = IW'(768);
      step();
      i_reset = 1'b1;
      i_result = IW'(1024);
      step();
      i_reset = 1'b0;
      i_ce = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_fill !== 3'd0) begin errors++; $display("FAIL mrst_fifo: got valid %b fill %0d expected 0/0", o_valid, o_fill); end
      checks++; if (o_sat !== 1'b0 || o_dropped !== 1'b0) begin errors++; $display("FAIL mrst_flags: got sat %b dropped %b expected 0/0", o_sat, o_dropped); end
      step();
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mrst_inflight: got %b expected 0", o_valid); end
      i_ce = 1'b1;
      i_result = IW'(512);
      step();
      i_ce = 1'b0;
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mrst_lat2: got %b expected 0", o_valid); end
      step();
      checks++; if (o_valid !== 1'b1 || o_data !== 16'd2 || o_fill !== 3'd1) begin errors++; $display("FAIL mrst_first: got %0d/%b fill %0d expected 2/1 fill 1", o_data, o_valid, o_fill); end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_overflow();
      test_full_rw();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
